// File: rtl/mem_access.sv
// mem_access: memory-stage access unit between EX/MEM and MEM/WB.
// Issues loads/stores over a valid/addr_ok/data_ok bus, lane-aligns store
// data, aligns and extends load data, and stalls upstream while busy.
// Optional feature macro: MISALIGN_TRAP_EN (in-place misaligned-access trap).
module mem_access #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [XLEN-1:0] in_result,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            mem_stall,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data,
  output logic            out_misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [2:0]      ldOff;
  logic [1:0]      ldSize;
  logic            ldUnsigned;
  logic            ldIsStore;
  logic [XLEN-1:0] capData;

  logic            isMem;
  logic            accept;
  logic            misalign;
  logic            issue;
  logic [7:0]      byteMask;
  logic [7:0]      strobeNext;
  logic [XLEN-1:0] wdataNext;
  logic [XLEN-1:0] rdShifted;
  logic [XLEN-1:0] loadExt;

  // Address-accepted is informational only; the access completes on data_ok.
  logic unusedAddrOk;
  assign unusedAddrOk = dresp_addr_ok;

  // Decode the incoming EX/MEM entry and form the store lanes.
  always_comb begin
    isMem  = in_load | in_store;
    accept = (state == IDLE) && in_valid;
    unique case (in_size)
      2'd0:    byteMask = 8'h01;
      2'd1:    byteMask = 8'h03;
      2'd2:    byteMask = 8'h0F;
      default: byteMask = 8'hFF;
    endcase
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    unique case (in_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = isMem && in_addr[0];
      2'd2:    misalign = isMem && (in_addr[1:0] != 2'b00);
      default: misalign = isMem && (in_addr[2:0] != 3'b000);
    endcase
`endif
    issue = accept && isMem && !misalign;
    // in_store wins when both load and store are flagged.
    strobeNext = in_store ? (byteMask << in_addr[2:0]) : '0;
    wdataNext  = in_wdata << {in_addr[2:0], 3'b000};
  end

  // Align and extend the returned load data using the latched access shape.
  always_comb begin
    rdShifted = dresp_data >> {ldOff, 3'b000};
    unique case (ldSize)
      2'd0:    loadExt = {{(XLEN-8){~ldUnsigned & rdShifted[7]}},   rdShifted[7:0]};
      2'd1:    loadExt = {{(XLEN-16){~ldUnsigned & rdShifted[15]}}, rdShifted[15:0]};
      2'd2:    loadExt = {{(XLEN-32){~ldUnsigned & rdShifted[31]}}, rdShifted[31:0]};
      default: loadExt = rdShifted;
    endcase
  end

  // Same-cycle responses for non-memory ops and traps; captured result in DONE.
  always_comb begin
    mem_stall    = issue || (state == BUSY);
    out_valid    = (accept && (!isMem || misalign)) || (state == DONE);
    out_misalign = accept && misalign;
    if (state == DONE)
      out_data = capData;
    else if (accept && misalign)
      out_data = in_addr;
    else if (accept && !isMem)
      out_data = in_result;
    else
      out_data = '0;
  end

  // Access FSM: latch the request on issue, wait for data_ok, present result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_size   <= '0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      ldOff       <= '0;
      ldSize      <= '0;
      ldUnsigned  <= 1'b0;
      ldIsStore   <= 1'b0;
      capData     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            state       <= BUSY;
            dreq_valid  <= 1'b1;
            dreq_addr   <= in_addr;
            dreq_size   <= {1'b0, in_size};
            dreq_strobe <= strobeNext;
            dreq_data   <= wdataNext;
            ldOff       <= in_addr[2:0];
            ldSize      <= in_size;
            ldUnsigned  <= in_unsigned;
            ldIsStore   <= in_store;
          end
        end
        BUSY: begin
          if (dresp_data_ok) begin
            state      <= DONE;
            dreq_valid <= 1'b0;
            capData    <= ldIsStore ? '0 : loadExt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
